// File: rtl/adc_serial_transmitter_if.sv
// adc_serial_transmitter_if: write port, status and CS/sdata link of the ADC emulator
interface adc_serial_transmitter_if #(
  parameter int DATA_W  = 16,
  parameter int FIFO_AW = 2
);
  logic              CS;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              sdata;
  logic              full;
  logic              empty;
  logic [FIFO_AW:0]  count;
  logic              tx_busy;
  logic              tx_done_tick;
  logic              overflow;
  logic              underflow;
  modport master (
    output CS, wr_en, wr_data,
    input  sdata, full, empty, count, tx_busy, tx_done_tick, overflow, underflow
  );
  modport slave (
    input  CS, wr_en, wr_data,
    output sdata, full, empty, count, tx_busy, tx_done_tick, overflow, underflow
  );
endinterface

// File: rtl/adc_serial_transmitter.sv
// adc_serial_transmitter: FIFO-buffered serial ADC emulator, one MSB-first word per CS-low window (ADC_LEAD_ZEROS_EN: 4 leading zeros + 12-bit sample)
module adc_serial_transmitter #(
  parameter int DATA_W  = 16,
  parameter int FIFO_AW = 2
) (
  input logic                   SCLK,
  input logic                   reset,
  adc_serial_transmitter_if.slave bus
);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
  state_t            state, state_n;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]  count;
  logic [DATA_W-1:0] shreg, shreg_n, head, load_word;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
  logic              cs_d, sdata, sdata_n;
  logic              done_q, done_n, under_q, under_n, over_q, over_n;
  logic              start, pop, push, full, empty;
  assign full  = count == DEPTH_C;
  assign empty = count == '0;
  assign start = state == IDLE && !bus.CS && cs_d;
  assign pop   = start && !empty;
  assign push  = bus.wr_en && (!full || pop);
  assign head  = mem[rd_ptr];
`ifdef ADC_LEAD_ZEROS_EN
  assign load_word = pop ? head & {4'b0000, {(DATA_W-4){1'b1}}} : '0;
`else
  assign load_word = pop ? head : '0;
`endif
  // next-state logic: frame start loads the head word, SHIFT walks bits MSB first, HOLD sends zeros until CS rises
  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    sdata_n   = 1'b0;
    done_n    = 1'b0;
    under_n   = 1'b0;
    over_n    = bus.wr_en && full && !pop;
    case (state)
      IDLE: if (start) begin
        state_n   = SHIFT;
        shreg_n   = load_word;
        sdata_n   = load_word[DATA_W-1];
        bit_cnt_n = CNT_MAX;
        under_n   = empty;
      end
      SHIFT: if (bus.CS) begin
        state_n = IDLE;
      end else if (bit_cnt == '0) begin
        state_n = HOLD;
        done_n  = 1'b1;
      end else begin
        shreg_n   = shreg << 1;
        sdata_n   = shreg[DATA_W-2];
        bit_cnt_n = bit_cnt - 1'b1;
      end
      HOLD: state_n = bus.CS ? IDLE : HOLD;
      default: state_n = IDLE;
    endcase
  end
  // FSM, shifter, pulses and FIFO pointers; async reset abandons any frame and empties the FIFO
  always_ff @(posedge SCLK or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      sdata   <= 1'b0;
      cs_d    <= 1'b1;
      done_q  <= 1'b0;
      under_q <= 1'b0;
      over_q  <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      bit_cnt <= bit_cnt_n;
      sdata   <= sdata_n;
      cs_d    <= bus.CS;
      done_q  <= done_n;
      under_q <= under_n;
      over_q  <= over_n;
      wr_ptr  <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr  <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count   <= count + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
    end
  end
  // FIFO storage; the head is read before a same-cycle write lands on a full FIFO
  always_ff @(posedge SCLK) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end
  assign bus.sdata        = sdata;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.count        = count;
  assign bus.tx_busy      = state == SHIFT;
  assign bus.tx_done_tick = done_q;
  assign bus.overflow     = over_q;
  assign bus.underflow    = under_q;
endmodule

// File: tb/tb_adc_serial_transmitter.sv
// tb_adc_serial_transmitter: scoreboard bench for the serial ADC emulator
module tb_adc_serial_transmitter;
  localparam int DATA_W  = 16;
  localparam int FIFO_AW = 2;
  logic SCLK = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  logic [DATA_W-1:0] model_q [$];
  logic exp_bits [$];
  logic exp_done [$];
  adc_serial_transmitter_if #(.DATA_W(DATA_W), .FIFO_AW(FIFO_AW)) bus ();
  adc_serial_transmitter #(.DATA_W(DATA_W), .FIFO_AW(FIFO_AW)) dut (
    .SCLK (SCLK),
    .reset(reset),
    .bus  (bus)
  );
  always #5 SCLK = ~SCLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [DATA_W-1:0] frame_word(input logic [DATA_W-1:0] w);
`ifdef ADC_LEAD_ZEROS_EN
    return {4'b0000, w[DATA_W-5:0]};
`else
    return w;
`endif
  endfunction
  task automatic write(input logic [DATA_W-1:0] w);
    logic exp_over;
    @(negedge SCLK);
    bus.wr_en = 1'b1;
    bus.wr_data = w;
    exp_over = model_q.size() == 4;
    if (!exp_over) model_q.push_back(w);
    @(negedge SCLK);
    bus.wr_en = 1'b0;
    check("overflow", 32'(bus.overflow), 32'(exp_over));
    check("count", 32'(bus.count), 32'(model_q.size()));
    check("full", 32'(bus.full), 32'(model_q.size() == 4));
  endtask
  task automatic frame(input int n_low, input bit wr, input logic [DATA_W-1:0] wd);
    logic [DATA_W-1:0] w;
    logic under, over;
    under = model_q.size() == 0;
    w = under ? '0 : frame_word(model_q.pop_front());
    over = wr && model_q.size() == 4;
    if (wr && !over) model_q.push_back(wd);
    for (int i = 0; i < n_low; i++) begin
      exp_bits.push_back(i < DATA_W ? w[DATA_W-1-i] : 1'b0);
      exp_done.push_back(i == DATA_W);
    end
    @(negedge SCLK);
    bus.CS = 1'b0;
    if (wr) begin
      bus.wr_en = 1'b1;
      bus.wr_data = wd;
    end
    for (int i = 0; i < n_low; i++) begin
      @(negedge SCLK);
      if (i == 0) begin
        bus.wr_en = 1'b0;
        check("underflow", 32'(bus.underflow), 32'(under));
        check("overflow_pop", 32'(bus.overflow), 32'(over));
        check("count_start", 32'(bus.count), 32'(model_q.size()));
      end else begin
        check("underflow_idle", 32'(bus.underflow), 32'(0));
      end
      check($sformatf("sdata[%0d]", i), 32'(bus.sdata), 32'(exp_bits.pop_front()));
      check($sformatf("done[%0d]", i), 32'(bus.tx_done_tick), 32'(exp_done.pop_front()));
      check($sformatf("busy[%0d]", i), 32'(bus.tx_busy), 32'(i < DATA_W));
    end
    bus.CS = 1'b1;
    @(negedge SCLK);
    check("end_sdata", 32'(bus.sdata), 32'(0));
    check("end_done", 32'(bus.tx_done_tick), 32'(0));
    check("end_busy", 32'(bus.tx_busy), 32'(0));
    check("end_empty", 32'(bus.empty), 32'(model_q.size() == 0));
    @(negedge SCLK);
  endtask
  initial begin
    logic [DATA_W-1:0] w;
    bus.CS = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_data = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #11;
    check("rst_sdata", 32'(bus.sdata), 32'(0));
    check("rst_full", 32'(bus.full), 32'(0));
    check("rst_empty", 32'(bus.empty), 32'(1));
    check("rst_count", 32'(bus.count), 32'(0));
    check("rst_busy", 32'(bus.tx_busy), 32'(0));
    check("rst_pulses", 32'({bus.tx_done_tick, bus.overflow, bus.underflow}), 32'(0));
    @(negedge SCLK);
    reset = 1'b1;
    @(negedge SCLK);
    write(16'hA5C3);
    frame(22, 1'b0, '0);
    write(16'h1234);
    write(16'hFFFF);
    write(16'h0001);
    write(16'h8000);
    write(16'h5555);
    frame(17, 1'b1, 16'h7777);
    for (int k = 0; k < 4; k++) frame(17, 1'b0, '0);
    frame(20, 1'b0, '0);
    write(16'hF0F0);
    frame(8, 1'b0, '0);
    frame(17, 1'b1, 16'h3C3C);
    frame(17, 1'b0, '0);
    write(16'hFABC);
    frame(17, 1'b0, '0);
    write(16'h0F0F);
    write(16'h2222);
    write(16'h3333);
    w = frame_word(model_q[0]);
    @(negedge SCLK);
    bus.CS = 1'b0;
    repeat (6) @(negedge SCLK);
    check("pre_rst_bit", 32'(bus.sdata), 32'(w[DATA_W-1-5]));
    #2 reset = 1'b0;
    #1;
    model_q.delete();
    check("mid_rst_sdata", 32'(bus.sdata), 32'(0));
    check("mid_rst_empty", 32'(bus.empty), 32'(1));
    check("mid_rst_count", 32'(bus.count), 32'(0));
    check("mid_rst_busy", 32'(bus.tx_busy), 32'(0));
    bus.CS = 1'b1;
    @(negedge SCLK);
    reset = 1'b1;
    @(negedge SCLK);
    frame(17, 1'b0, '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
